// File: rtl/intensity.sv
// intensity: converts a 3x3 window of RGB pixels into a 3x3 grid of 8-bit luma values, 2-cycle latency.
// Optional macro INTENSITY_ROUND_EN selects round-half-up instead of truncation.
`default_nettype none

module intensity #(
    parameter int W_R = 77,
    parameter int W_G = 150,
    parameter int W_B = 29
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic [215:0] pixelData,
    output logic [71:0]  iGrid
);

    localparam logic [15:0] c_WR = 16'(W_R);
    localparam logic [15:0] c_WG = 16'(W_G);
    localparam logic [15:0] c_WB = 16'(W_B);

`ifdef INTENSITY_ROUND_EN
    localparam logic [16:0] c_RND = 17'd128;
`else
    localparam logic [16:0] c_RND = 17'd0;
`endif

    // The >>8 normalisation is only exact when the weights sum to 256.
    if (W_R + W_G + W_B != 256) begin : g_weight_check
        $error("intensity: W_R + W_G + W_B must equal 256");
    end

    for (genvar k = 0; k < 9; k++) begin : g_lane
        logic [7:0]  w_r;
        logic [7:0]  w_g;
        logic [7:0]  w_b;
        logic [15:0] w_sum;
        logic [16:0] w_rnd;
        logic [16:0] w_q;
        logic [15:0] r_sum;
        logic [7:0]  r_int;

        assign {w_r, w_g, w_b} = pixelData[215-24*k -: 24];
        assign w_sum = c_WR * {8'd0, w_r} + c_WG * {8'd0, w_g} + c_WB * {8'd0, w_b};

        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                r_sum <= 16'd0;
            end else begin
                r_sum <= w_sum;
            end
        end

        assign w_rnd = {1'b0, r_sum} + c_RND;
        assign w_q   = w_rnd >> 8;

        // Upper quotient bits cannot be set for valid weights; saturating keeps them accounted for.
        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                r_int <= 8'd0;
            end else begin
                r_int <= (|w_q[16:8]) ? 8'hFF : w_q[7:0];
            end
        end

        assign iGrid[71-8*k -: 8] = r_int;
    end

endmodule

`default_nettype wire

// File: tb/tb_intensity.sv
// tb_intensity: directed self-checking bench for the intensity pipeline.
`default_nettype none

module tb_intensity;

    logic         clk;
    logic         n_rst;
    logic [215:0] pix;
    logic [71:0]  grid;

    int n_pass  = 0;
    int n_total = 0;

    intensity dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .pixelData (pix),
        .iGrid     (grid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef INTENSITY_ROUND_EN
    localparam logic [7:0] c_EXP_RED  = 8'd77;
    localparam logic [7:0] c_EXP_BLUE = 8'd29;
`else
    localparam logic [7:0] c_EXP_RED  = 8'd76;
    localparam logic [7:0] c_EXP_BLUE = 8'd28;
`endif

    function automatic logic [215:0] fill(input logic [23:0] p);
        return {9{p}};
    endfunction

    task automatic test_reset;
        n_rst = 1'b1;
        pix   = '0;
        #1 n_rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int k = 0; k < 9; k++) pix[24*k +: 24] = 24'($urandom);
            #1;
            n_total++;
            if (grid !== 72'd0) $display("FAIL reset_hold[%0d]: got %h want 0", c, grid);
            else n_pass++;
        end
        @(negedge clk);
        n_rst = 1'b1;
        pix   = fill(24'hFFFFFF);
        @(negedge clk);
        n_total++;
        if (grid !== 72'd0) $display("FAIL reset_release_1edge: got %h want 0", grid);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (grid !== {9{8'hFF}}) $display("FAIL reset_release_2edge: got %h want %h", grid, {9{8'hFF}});
        else n_pass++;
    endtask

    task automatic test_primaries;
        logic [23:0] col [3];
        logic [7:0]  exp_v [3];
        col[0] = 24'hFF0000; exp_v[0] = c_EXP_RED;
        col[1] = 24'h00FF00; exp_v[1] = 8'd149;
        col[2] = 24'h0000FF; exp_v[2] = c_EXP_BLUE;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pix = fill(col[i]);
            @(negedge clk);
            @(negedge clk);
            n_total++;
            if (grid !== {9{exp_v[i]}})
                $display("FAIL primary[%0d]: got %h want %h", i, grid, {9{exp_v[i]}});
            else n_pass++;
        end
    endtask

    task automatic test_gray_extremes;
        logic [71:0] exp_g;
        exp_g = {8'd0, 8'd255, 8'd100, {6{8'd22}}};
        @(negedge clk);
        pix = {24'h000000, 24'hFFFFFF, {3{8'd100}}, {6{8'd20, 8'd20, 8'd40}}};
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (grid !== exp_g) $display("FAIL gray_extremes: got %h want %h", grid, exp_g);
        else n_pass++;
    endtask

    task automatic test_lane_order;
        @(negedge clk);
        pix = {192'd0, 24'hFFFFFF};
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (grid !== 72'h0000_0000_0000_0000_FF) $display("FAIL lane8_only: got %h want %h", grid, 72'hFF);
        else n_pass++;
        pix = {24'hFFFFFF, 192'd0};
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (grid !== {8'hFF, 64'd0}) $display("FAIL lane0_only: got %h want %h", grid, {8'hFF, 64'd0});
        else n_pass++;
    endtask

    // Window w carries gray level 10*w+k+1 in lane k, so each lane must reproduce its own level.
    task automatic test_back_to_back;
        logic [71:0] exp_q [6];
        logic [7:0]  v;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (t >= 2) begin
                n_total++;
                if (grid !== exp_q[t-2]) $display("FAIL stream[%0d]: got %h want %h", t-2, grid, exp_q[t-2]);
                else n_pass++;
            end
            if (t < 6) begin
                for (int k = 0; k < 9; k++) begin
                    v = 8'(10*t + k + 1);
                    pix[215-24*k -: 24] = {v, v, v};
                    exp_q[t][71-8*k -: 8] = v;
                end
            end else begin
                pix = '0;
            end
        end
    endtask

    task automatic test_midstream_reset;
        @(negedge clk);
        pix = fill(24'h505050);
        @(negedge clk);
        pix = fill(24'h606060);
        @(posedge clk);
        #2 n_rst = 1'b0;
        #1;
        n_total++;
        if (grid !== 72'd0) $display("FAIL midreset_async_clear: got %h want 0", grid);
        else n_pass++;
        @(negedge clk);
        n_rst = 1'b1;
        pix   = fill(24'h404040);
        @(negedge clk);
        n_total++;
        if (grid !== 72'd0) $display("FAIL midreset_1edge: got %h want 0", grid);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (grid !== {9{8'h40}}) $display("FAIL midreset_2edge: got %h want %h", grid, {9{8'h40}});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_primaries();
        test_gray_extremes();
        test_lane_order();
        test_back_to_back();
        test_midstream_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
